serial_adder_ctrl: RTL and testbench

- Bit-serial adder that reuses a single `fulladder` instance over WIDTH clock cycles, one bit per cycle, LSB first.
- Operands are accepted on a valid/ready input handshake, shifted through the full adder, and the sum and carry-out are presented on a valid/ready output handshake.
- It is the sequencer for the 1-bit adder cell: an area-minimal adder for multi-cycle ALU paths.

---
 rtl/serial_adder_pkg.sv | 24 ++
 rtl/fulladder.sv | 18 +
 rtl/serial_adder_ctrl.sv | 120 ++++++++++++
 tb/tb_serial_adder_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_adder_pkg : state encoding and counter sizing for serial_adder_ctrl
// Revision: 1.0
// ---------------------------------------------------------------------------
package serial_adder_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_RUN  = RUN,
    ST_DONE = DONE
  } state_e;

  // A one-bit operand still needs a one-bit counter.
  function automatic int calc_cnt_w(input int width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fulladder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fulladder : combinational 1-bit full adder (S = sum, P = carry out)
// Revision: 1.0
// ---------------------------------------------------------------------------
module fulladder (
  input  logic a,
  input  logic b,
  input  logic Pin,
  output logic S,
  output logic P
);

  assign S = a ^ b ^ Pin;
  assign P = (a & b) | (a & Pin) | (b & Pin);

endmodule
`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_adder_ctrl : bit-serial adder, one fulladder reused LSB first over
// WIDTH cycles, with valid/ready handshakes on operands and result.
// Revision: 1.0
// ---------------------------------------------------------------------------
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             c_out,
  output logic             busy
);

  localparam int              CNT_W    = calc_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             fa_s;
  logic             fa_p;
  logic [WIDTH-1:0] sum_shift;

  fulladder u_fa (
    .a   (a_sh_q[0]),
    .b   (b_sh_q[0]),
    .Pin (carry_q),
    .S   (fa_s),
    .P   (fa_p)
  );

  // New sum bits enter at the MSB so bit 0 lands at position 0 after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_sum_w1
      assign sum_shift = fa_s;
    end else begin : g_sum_wn
      assign sum_shift = {fa_s, sum_sh_q[WIDTH-1:1]};
    end
  endgenerate

  assign in_ready  = rst_n && (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign sum_out   = out_valid ? sum_sh_q : '0;
  assign c_out     = out_valid ? carry_q  : 1'b0;

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          a_sh_d   = a_in;
          b_sh_d   = b_in;
          carry_d  = c_in;
          cnt_d    = '0;
          sum_sh_d = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        sum_sh_d = sum_shift;
        carry_d  = fa_p;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_serial_adder_ctrl : directed vectors for serial_adder_ctrl, WIDTH=8 and 1
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       in_valid8, in_ready8, out_valid8, out_ready8, c_in8, c_out8, busy8;
  logic [7:0] a_in8, b_in8, sum_out8;

  logic       in_valid1, in_ready1, out_valid1, out_ready1, c_in1, c_out1, busy1;
  logic [0:0] a_in1, b_in1, sum_out1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a_in(a_in8), .b_in(b_in8), .c_in(c_in8), .out_valid(out_valid8),
    .out_ready(out_ready8), .sum_out(sum_out8), .c_out(c_out8), .busy(busy8)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a_in(a_in1), .b_in(b_in1), .c_in(c_in1), .out_valid(out_valid1),
    .out_ready(out_ready1), .sum_out(sum_out1), .c_out(c_out1), .busy(busy1)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [7:0] sum;
    logic       co;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Accept one operand set on dut8 and wait for DONE; returns latency in edges.
  task automatic start_and_wait(input logic [7:0] a, input logic [7:0] b, input logic c,
                                output int lat);
    check("in_ready_before_accept", in_ready8, 1);
    in_valid8 = 1'b1; a_in8 = a; b_in8 = b; c_in8 = c;
    tick();
    in_valid8 = 1'b0; a_in8 = 8'hxx; b_in8 = 8'hxx; c_in8 = 1'bx;
    check("in_ready_after_accept", in_ready8, 0);
    lat = 0;
    while (!out_valid8 && lat < 50) begin
      tick();
      lat++;
    end
  endtask

  task automatic consume();
    out_ready8 = 1'b1;
    tick();
    out_ready8 = 1'b0;
    check("in_ready_after_consume", in_ready8, 1);
    check("out_valid_after_consume", out_valid8, 0);
  endtask

  vec_t vecs[7];

  initial begin
    int lat;
    int acc_cyc[2];
    int nacc;
    int nres;
    logic [7:0] res_sum[2];
    logic       res_co[2];

    vecs[0] = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1};
    vecs[5] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
    vecs[6] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};

    rst_n = 1'b0;
    in_valid8 = 0; out_ready8 = 0; a_in8 = 0; b_in8 = 0; c_in8 = 0;
    in_valid1 = 0; out_ready1 = 0; a_in1 = 0; b_in1 = 0; c_in1 = 0;
    tick(); tick();
    check("rst_in_ready", in_ready8, 0);
    check("rst_out_valid", out_valid8, 0);
    check("rst_busy", busy8, 0);
    check("rst_sum", sum_out8, 0);
    check("rst_cout", c_out8, 0);
    rst_n = 1'b1;
    #1;
    check("idle_in_ready", in_ready8, 1);

    for (int i = 0; i < 7; i++) begin
      start_and_wait(vecs[i].a, vecs[i].b, vecs[i].c, lat);
      check($sformatf("vec%0d_latency", i), lat, 8);
      check($sformatf("vec%0d_sum", i), sum_out8, vecs[i].sum);
      check($sformatf("vec%0d_cout", i), c_out8, vecs[i].co);
      check($sformatf("vec%0d_busy", i), busy8, 1);
      consume();
    end

    // Backpressure: result held while out_ready is low; in_valid ignored.
    start_and_wait(8'h12, 8'h34, 1'b0, lat);
    check("bp_latency", lat, 8);
    for (int i = 0; i < 5; i++) begin
      in_valid8 = i[0]; a_in8 = 8'hEE; b_in8 = 8'hEE; c_in8 = 1'b1;
      tick();
      check("bp_sum_hold", sum_out8, 8'h46);
      check("bp_valid_hold", out_valid8, 1);
      check("bp_in_ready_low", in_ready8, 0);
    end
    in_valid8 = 1'b0;
    check("bp_cout", c_out8, 0);
    consume();

    // Reset during the third RUN cycle discards the operation.
    in_valid8 = 1'b1; a_in8 = 8'hFF; b_in8 = 8'hFF; c_in8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    tick(); tick();
    check("midrun_busy", busy8, 1);
    rst_n = 1'b0;
    tick();
    check("midrun_rst_busy", busy8, 0);
    check("midrun_rst_valid", out_valid8, 0);
    rst_n = 1'b1;
    tick();
    check("midrun_no_emit", out_valid8, 0);
    start_and_wait(8'h01, 8'h01, 1'b0, lat);
    check("post_rst_latency", lat, 8);
    check("post_rst_sum", sum_out8, 8'h02);
    check("post_rst_cout", c_out8, 0);
    consume();

    // Back-to-back with in_valid held and out_ready tied high.
    out_ready8 = 1'b1;
    in_valid8 = 1'b1; a_in8 = 8'h10; b_in8 = 8'h20; c_in8 = 1'b0;
    nacc = 0; nres = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      logic acc;
      acc = in_valid8 && in_ready8;
      if (acc && nacc < 2) acc_cyc[nacc] = cyc;
      if (out_valid8 && nres < 2) begin
        res_sum[nres] = sum_out8;
        res_co[nres]  = c_out8;
        nres++;
      end
      tick();
      if (acc) begin
        nacc++;
        if (nacc == 1) begin a_in8 = 8'h7F; b_in8 = 8'h01; end
        else in_valid8 = 1'b0;
      end
    end
    out_ready8 = 1'b0;
    check("b2b_accepts", nacc, 2);
    check("b2b_results", nres, 2);
    if (nacc == 2) check("b2b_spacing", acc_cyc[1] - acc_cyc[0], 10);
    if (nres == 2) begin
      check("b2b_sum0", res_sum[0], 8'h30);
      check("b2b_cout0", res_co[0], 0);
      check("b2b_sum1", res_sum[1], 8'h80);
      check("b2b_cout1", res_co[1], 0);
    end

    // WIDTH=1: 1 + 1 + 1.
    check("w1_in_ready", in_ready1, 1);
    in_valid1 = 1'b1; a_in1 = 1'b1; b_in1 = 1'b1; c_in1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    check("w1_run_no_valid", out_valid1, 0);
    tick();
    check("w1_valid", out_valid1, 1);
    check("w1_sum", sum_out1, 1);
    check("w1_cout", c_out1, 1);
    out_ready1 = 1'b1;
    tick();
    out_ready1 = 1'b0;
    check("w1_idle", in_ready1, 1);
    in_valid1 = 1'b1; a_in1 = 1'b0; b_in1 = 1'b1; c_in1 = 1'b0;
    tick();
    in_valid1 = 1'b0;
    tick();
    check("w1_valid2", out_valid1, 1);
    check("w1_sum2", sum_out1, 1);
    check("w1_cout2", c_out1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
